// File: rtl/plant_pkg.sv
// Shared constants and state encoding for the plant controller and its sensor front end.
// Optional build macro: SENSOR_PARITY_EN adds an even-parity bit to each ADC frame.
package plant_pkg;

    localparam int unsigned TEMP_W  = 3;
    localparam int unsigned WATER_W = 4;
    localparam int unsigned RAW_W   = 8;

`ifdef SENSOR_PARITY_EN
    localparam int unsigned FRAME_BITS = 2 * RAW_W + 1;
`else
    localparam int unsigned FRAME_BITS = 2 * RAW_W;
`endif

    localparam int unsigned BIT_CNT_W = $clog2(FRAME_BITS + 1);

    typedef enum logic [2:0] {
        StIdle,
        StSelect,
        StShift,
        StLatch,
        StWait
    } state_e;

endpackage

// File: rtl/sensor_poll_master_if.sv
// Sensor-side serial link plus the quantized codes handed to the plant controller.
interface sensor_poll_master_if;
    import plant_pkg::*;

    logic               start;
    logic               miso;
    logic               cs_n;
    logic               sclk;
    logic [TEMP_W-1:0]  temperature;
    logic [WATER_W-1:0] water;
    logic               sample_valid;
    logic               frame_err;

    modport master (
        input  start, miso,
        output cs_n, sclk, temperature, water, sample_valid, frame_err
    );

    modport slave (
        output start, miso,
        input  cs_n, sclk, temperature, water, sample_valid, frame_err
    );

endinterface

// File: rtl/sensor_poll_master_sclk_gen.sv
// Half-period divider for the ADC serial clock, with sample strobe and bit counter.
module sclk_gen
    import plant_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic run_i,      // count half-periods (select setup and shifting)
    input  logic shift_i,    // let sclk toggle at half-period ends
    output logic sclk_o,
    output logic half_end_o,
    output logic sample_o,   // last clk cycle of an sclk high phase
    output logic done_o      // sample strobe of the final frame bit
);

    localparam int unsigned DIV_W = $clog2(CLK_DIV);

    logic [DIV_W-1:0]     div_q, div_d;
    logic                 sclk_q, sclk_d;
    logic [BIT_CNT_W-1:0] bit_q, bit_d;

    // Strobes and next-state for the divider, sclk phase and bit count.
    always_comb begin
        half_end_o = run_i && (div_q == DIV_W'(CLK_DIV - 1));
        sample_o   = half_end_o && shift_i && sclk_q;
        done_o     = sample_o && (bit_q == BIT_CNT_W'(FRAME_BITS - 1));

        div_d  = '0;
        sclk_d = 1'b0;
        bit_d  = '0;
        if (run_i) begin
            div_d = half_end_o ? '0 : div_q + 1'b1;
            bit_d = sample_o ? bit_q + 1'b1 : bit_q;
            if (shift_i) begin
                sclk_d = half_end_o ? ~sclk_q : sclk_q;
            end
        end
    end

    // Divider state; reset clears everything so an aborted frame leaves sclk low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q  <= '0;
            sclk_q <= 1'b0;
            bit_q  <= '0;
        end else begin
            div_q  <= div_d;
            sclk_q <= sclk_d;
            bit_q  <= bit_d;
        end
    end

    assign sclk_o = sclk_q;

endmodule

// File: rtl/sensor_poll_master.sv
// Periodic two-channel ADC poller producing temperature/water codes for the plant controller.
// Optional build macro: SENSOR_PARITY_EN checks a trailing even-parity bit and flags bad frames.
module sensor_poll_master
    import plant_pkg::*;
#(
    parameter int unsigned CLK_DIV       = 4,
    parameter int unsigned SAMPLE_PERIOD = 1000
) (
    input logic                  clk,
    input logic                  reset,
    sensor_poll_master_if.master bus
);

    localparam int unsigned PER_W = $clog2(SAMPLE_PERIOD);
    localparam logic [PER_W-1:0] PER_MAX = PER_W'(SAMPLE_PERIOD - 1);
    localparam int unsigned T_MSB = FRAME_BITS - 1;
    localparam int unsigned W_MSB = FRAME_BITS - 1 - RAW_W;

    state_e                  state_q, state_d;
    logic [PER_W-1:0]        per_q, per_d;
    logic [FRAME_BITS-1:0]   shreg_q, shreg_d;
    logic                    cs_n_q, cs_n_d;
    logic [TEMP_W-1:0]       temp_q, temp_d;
    logic [WATER_W-1:0]      water_q, water_d;
    logic                    valid_q, valid_d;
    logic                    parity_ok;
    logic                    sclk, half_end, sample, done;
    logic                    run, shift;

    assign run   = (state_q == StSelect) || (state_q == StShift);
    assign shift = (state_q == StShift);

    sclk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_sclk_gen (
        .clk       (clk),
        .reset     (reset),
        .run_i     (run),
        .shift_i   (shift),
        .sclk_o    (sclk),
        .half_end_o(half_end),
        .sample_o  (sample),
        .done_o    (done)
    );

`ifdef SENSOR_PARITY_EN
    logic frame_err_q, frame_err_d;
    assign parity_ok   = ~^shreg_q;
    assign frame_err_d = (state_q == StLatch) && !parity_ok;
    assign bus.frame_err = frame_err_q;
`else
    assign parity_ok     = 1'b1;
    assign bus.frame_err = 1'b0;
`endif

    // Frame sequencing; the period counter saturates at SAMPLE_PERIOD-1 so it never wraps.
    always_comb begin
        state_d = state_q;
        cs_n_d  = cs_n_q;
        shreg_d = shreg_q;
        temp_d  = temp_q;
        water_d = water_q;
        valid_d = 1'b0;
        per_d   = (per_q == PER_MAX) ? per_q : per_q + 1'b1;

        case (state_q)
            StIdle: begin
                per_d = '0;
                if (bus.start) begin
                    state_d = StSelect;
                    cs_n_d  = 1'b0;
                end
            end
            StSelect: begin
                if (half_end) begin
                    state_d = StShift;
                end
            end
            StShift: begin
                if (sample) begin
                    shreg_d = {shreg_q[FRAME_BITS-2:0], bus.miso};
                end
                if (done) begin
                    state_d = StLatch;
                    cs_n_d  = 1'b1;
                end
            end
            StLatch: begin
                // Keep the top bits of each raw byte; a bad frame leaves the codes untouched.
                if (parity_ok) begin
                    temp_d  = shreg_q[T_MSB -: TEMP_W];
                    water_d = shreg_q[W_MSB -: WATER_W];
                    valid_d = 1'b1;
                end
                state_d = StWait;
            end
            StWait: begin
                if (per_q == PER_MAX) begin
                    if (bus.start) begin
                        state_d = StSelect;
                        cs_n_d  = 1'b0;
                        per_d   = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Registered FSM state and outputs; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            per_q       <= '0;
            shreg_q     <= '0;
            cs_n_q      <= 1'b1;
            temp_q      <= '0;
            water_q     <= '0;
            valid_q     <= 1'b0;
`ifdef SENSOR_PARITY_EN
            frame_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            per_q       <= per_d;
            shreg_q     <= shreg_d;
            cs_n_q      <= cs_n_d;
            temp_q      <= temp_d;
            water_q     <= water_d;
            valid_q     <= valid_d;
`ifdef SENSOR_PARITY_EN
            frame_err_q <= frame_err_d;
`endif
        end
    end

    assign bus.cs_n         = cs_n_q;
    assign bus.sclk         = sclk;
    assign bus.temperature  = temp_q;
    assign bus.water        = water_q;
    assign bus.sample_valid = valid_q;

endmodule

// File: tb/tb_sensor_poll_master.sv
// Two pollers (long period and back-to-back) against a frame-timeline model and an ADC model.
module tb_sensor_poll_master;
    import plant_pkg::*;

    localparam int CD   = 4;
    localparam int FB   = FRAME_BITS;
    localparam int FL   = CD + 2 * CD * FB;   // cycles with cs_n low
    localparam int SP_A = 300;
    localparam int SP_B = 8;
`ifdef SENSOR_PARITY_EN
    localparam int LAT_LIT   = 141;
    localparam int PER_B_LIT = 142;
    localparam int BITS_LIT  = 17;
`else
    localparam int LAT_LIT   = 133;
    localparam int PER_B_LIT = 134;
    localparam int BITS_LIT  = 16;
`endif

    logic clk, reset, start;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    sensor_poll_master_if ifa ();
    sensor_poll_master_if ifb ();

    sensor_poll_master #(.CLK_DIV(CD), .SAMPLE_PERIOD(SP_A)) u_dut_a (
        .clk(clk), .reset(reset), .bus(ifa)
    );
    sensor_poll_master #(.CLK_DIV(CD), .SAMPLE_PERIOD(SP_B)) u_dut_b (
        .clk(clk), .reset(reset), .bus(ifb)
    );

    // Model: frame timeline position t (0 = first cs_n-low cycle) and expected codes.
    bit          act [2];
    int          t [2];
    logic [2:0]  et [2];
    logic [3:0]  ew [2];
    bit          esv [2], efe [2];
    // ADC model and observation bookkeeping.
    logic [16:0] fword [2], nword [2];
    bit          rnd [2];
    int          idx [2];
    bit          pcs [2], psclk [2];
    int          rises [2], nfalls [2], fall [2], prev_fall [2], sv_cyc [2], svc [2], fec [2];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, actual, expected);
        end
    endtask

    function automatic logic [16:0] make_word(input logic [7:0] rt, input logic [7:0] rw,
                                              input bit bad);
        logic [15:0] d;
        d = {rt, rw};
        if (FB == 16) return {1'b0, d};
        return {d, (^d) ^ bad};
    endfunction

    function automatic logic [16:0] rand_word();
        return make_word(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                         $urandom_range(0, 5) == 0);
    endfunction

    function automatic int tdec(input int i);
        int sp;
        sp = (i == 0) ? SP_A : SP_B;
        return (FL + 1 > sp - 1) ? FL + 1 : sp - 1;
    endfunction

    task automatic reset_model();
        for (int i = 0; i < 2; i++) begin
            act[i] = 0; t[i] = 0; et[i] = '0; ew[i] = '0; esv[i] = 0; efe[i] = 0;
        end
    endtask

    task automatic model_update(input int i);
        int d;
        esv[i] = 0;
        efe[i] = 0;
        if (!act[i]) begin
            if (start) begin act[i] = 1; t[i] = 0; end
        end else if (t[i] == tdec(i)) begin
            if (start) t[i] = 0;
            else act[i] = 0;
        end else begin
            t[i]++;
        end
        if (act[i] && t[i] == FL + 1) begin
            d = int'(fword[i] >> (FB - 16)) & 32'hFFFF;
            if (FB == 16 || (^fword[i]) == 1'b0) begin
                et[i]  = 3'((d >> 13) & 7);
                ew[i]  = 4'((d >> 4) & 15);
                esv[i] = 1;
            end else begin
                efe[i] = 1;
            end
        end
    endtask

    function automatic logic [10:0] exp_vec(input int i);
        logic cs, sc;
        cs = !(act[i] && t[i] < FL);
        sc = act[i] && t[i] >= CD && t[i] < FL && (((t[i] - CD) / CD) % 2 == 1);
        return {cs, sc, et[i], ew[i], esv[i], efe[i]};
    endfunction

    function automatic logic [10:0] obs(input int i);
        if (i == 0)
            return {ifa.cs_n, ifa.sclk, ifa.temperature, ifa.water, ifa.sample_valid, ifa.frame_err};
        return {ifb.cs_n, ifb.sclk, ifb.temperature, ifb.water, ifb.sample_valid, ifb.frame_err};
    endfunction

    function automatic int probe(input int which, input int i);
        case (which)
            0: return nfalls[i];
            1: return svc[i];
            2: return fec[i];
            default: return rises[i];
        endcase
    endfunction

    // ADC: loads a word at cs_n fall, presents MSB first, advances on each sclk fall.
    task automatic bookkeep(input int i);
        logic [10:0] o;
        logic cs, sc, m;
        o  = obs(i);
        cs = o[10];
        sc = o[9];
        if (pcs[i] && !cs) begin
            fword[i] = nword[i];
            if (rnd[i]) nword[i] = rand_word();
            idx[i] = 0; rises[i] = 0;
            prev_fall[i] = fall[i]; fall[i] = cyc; nfalls[i]++;
        end
        if (!cs && psclk[i] && !sc) idx[i]++;
        if (!cs && !psclk[i] && sc) rises[i]++;
        if (o[1]) begin svc[i]++; sv_cyc[i] = cyc; end
        if (o[0]) fec[i]++;
        m = (!cs && idx[i] < FB) ? fword[i][FB - 1 - idx[i]] : 1'b0;
        if (i == 0) ifa.miso = m;
        else ifb.miso = m;
        psclk[i] = sc;
        pcs[i]   = cs;
    endtask

    task automatic step();
        @(posedge clk);
        if (reset) for (int i = 0; i < 2; i++) model_update(i);
        @(negedge clk);
        cyc++;
        for (int i = 0; i < 2; i++) begin
            check(i == 0 ? "cycle_a" : "cycle_b", 32'(obs(i)), 32'(exp_vec(i)));
            bookkeep(i);
        end
    endtask

    task automatic wait_for(input int which, input int i, input int target, input int budget,
                            input string nm);
        int n;
        n = 0;
        while (probe(which, i) < target && n < budget) begin
            step();
            n++;
        end
        if (probe(which, i) < target) begin
            checks++;
            errors++;
            $display("FAIL %s: timed out after %0d cycles, count %0d, required %0d",
                     nm, budget, probe(which, i), target);
        end
    endtask

    task automatic set_start(input bit v);
        start = v;
        ifa.start = v;
        ifb.start = v;
    endtask

    initial begin
        int n;
        reset = 1'b1;
        set_start(1'b1);
        ifa.miso = 1'b0;
        ifb.miso = 1'b0;
        for (int i = 0; i < 2; i++) begin
            nword[i] = make_word(8'hA5, 8'h3C, 1'b0);
            fword[i] = '0; rnd[i] = 0; idx[i] = 0; pcs[i] = 1; psclk[i] = 0;
            rises[i] = 0; nfalls[i] = 0; fall[i] = 0; prev_fall[i] = 0;
            sv_cyc[i] = 0; svc[i] = 0; fec[i] = 0;
        end
        reset_model();
        #2 reset = 1'b0;

        // Reset held with start high.
        repeat (3) step();
        check("reset_cs_n", 32'(ifa.cs_n), 1);
        check("reset_sclk", 32'(ifa.sclk), 0);
        check("reset_temp", 32'(ifa.temperature), 0);
        check("reset_water", 32'(ifa.water), 0);
        reset = 1'b1;
        step();
        check("cs_fall_after_release", 32'(ifa.cs_n), 0);
        rnd[1] = 1;
        nword[1] = rand_word();

        // First frame A5/3C.
        wait_for(1, 0, 1, 200, "first_sample");
        check("first_latency", 32'(sv_cyc[0] - fall[0]), LAT_LIT);
        check("first_temp", 32'(ifa.temperature), 5);
        check("first_water", 32'(ifa.water), 3);
        check("first_sclk_rises", 32'(rises[0]), BITS_LIT);
        nword[0] = rand_word();
        step();
        check("valid_single_pulse", 32'(ifa.sample_valid), 0);

        // Frame spacing: 300-cycle period and back-to-back frames.
        wait_for(0, 0, 2, 400, "second_frame_a");
        check("period_a", 32'(fall[0] - prev_fall[0]), SP_A);
        check("period_b", 32'(fall[1] - prev_fall[1]), PER_B_LIT);

        // Drop start partway through an FF/FF frame.
        nword[0] = make_word(8'hFF, 8'hFF, 1'b0);
        wait_for(0, 0, 3, 400, "third_frame_a");
        wait_for(3, 0, 8, 200, "bit7_a");
        set_start(1'b0);
        n = svc[0];
        wait_for(1, 0, n + 1, 300, "drop_sample");
        check("drop_temp", 32'(ifa.temperature), 7);
        check("drop_water", 32'(ifa.water), 15);
        n = nfalls[0];
        repeat (400) step();
        check("no_frame_after_drop", 32'(nfalls[0] - n), 0);
        check("idle_cs_n", 32'(ifa.cs_n), 1);

        // Asynchronous reset at bit 10, then a fresh frame.
        set_start(1'b1);
        n = nfalls[0];
        wait_for(0, 0, n + 1, 10, "restart_a");
        wait_for(3, 0, 11, 200, "bit10_a");
        #2 reset = 1'b0;
        #1;
        check("abort_cs_n", 32'(ifa.cs_n), 1);
        check("abort_sclk", 32'(ifa.sclk), 0);
        check("abort_temp", 32'(ifa.temperature), 0);
        check("abort_water", 32'(ifa.water), 0);
        reset_model();
        nword[0] = make_word(8'hC3, 8'h96, 1'b0);
        repeat (2) step();
        reset = 1'b1;
        n = svc[0];
        wait_for(1, 0, n + 1, 200, "fresh_frame");
        check("fresh_rises", 32'(rises[0]), BITS_LIT);
        check("fresh_temp", 32'(ifa.temperature), 6);
        check("fresh_water", 32'(ifa.water), 9);

`ifdef SENSOR_PARITY_EN
        // Bad parity keeps the previous codes.
        nword[0] = make_word(8'h12, 8'h34, 1'b1);
        n = fec[0];
        wait_for(2, 0, n + 1, 400, "bad_parity");
        check("bad_parity_err", 32'(ifa.frame_err), 1);
        check("bad_parity_valid", 32'(ifa.sample_valid), 0);
        check("bad_parity_temp", 32'(ifa.temperature), 6);
        check("bad_parity_water", 32'(ifa.water), 9);
`endif
        nword[0] = make_word(8'h12, 8'h34, 1'b0);
        n = svc[0];
        wait_for(1, 0, n + 1, 400, "good_12_34");
        check("good_temp", 32'(ifa.temperature), 0);
        check("good_water", 32'(ifa.water), 3);
        check("good_frame_err", 32'(ifa.frame_err), 0);

        // Random data and random start toggling.
        rnd[0] = 1;
        nword[0] = rand_word();
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 199) == 0) set_start(!start);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sensor_poll_master.md
Name: sensor_poll_master

Overview:
- Front end that produces the `temperature`/`water` inputs consumed by `fsm_plant`.
- Periodically polls an external two-channel 8-bit ADC over a 3-wire serial link (`cs_n`, `sclk`, `miso`).
- Quantizes each raw byte to the controller's code widths and holds the codes stable between frames.
- Sits between the board-level sensor pins and the plant controller; shares the controller's `start` enable.

Parameters:
- CLK_DIV, 4: `clk` cycles per `sclk` half-period; legal range 2..255.
- SAMPLE_PERIOD, 1000: `clk` cycles from one frame start to the next. Legal values ≥ 8; values shorter than one frame give back-to-back frames.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  polling enable (same signal that drives `fsm_plant.start`).
- miso  in  1  serial data from ADC.
- cs_n  out  1  ADC chip select, active low.
- sclk  out  1  serial clock, idles low.
- temperature  out  3  quantized temperature code to `fsm_plant`.
- water  out  4  quantized moisture code to `fsm_plant`.
- sample_valid  out  1  one-cycle pulse when new codes are loaded.
- frame_err  out  1  one-cycle pulse on a rejected frame; tied 0 without the optional feature.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, cs_n=1, sclk=0.
  - temperature=0, water=0, sample_valid=0, frame_err=0.
  - All counters and the shift register are cleared.
  - Reset mid-frame aborts immediately: cs_n rises, partial data is discarded.
- FSM states: IDLE, SELECT, SHIFT, LATCH, WAIT.
- IDLE:
  - cs_n=1, sclk=0.
  - start=1 sampled → SELECT next cycle; the period counter restarts at 0 on SELECT entry.
- SELECT:
  - cs_n=0, sclk=0 for CLK_DIV cycles, then → SHIFT.
- SHIFT:
  - Register `sclk` toggles every CLK_DIV cycles, beginning low, for FRAME_BITS full periods.
  - The ADC drives `miso` on `sclk` falling edges.
  - The master samples `miso` on the last `clk` cycle of each `sclk` high phase.
  - Bits are MSB first: raw_t[7:0], then raw_w[7:0] (FRAME_BITS=16).
  - After the last bit, sclk=0 → LATCH.
- LATCH (1 cycle):
  - cs_n=1.
  - temperature ← raw_t[7:5], water ← raw_w[7:4] (truncation, no rounding).
  - sample_valid=1 in the same cycle the outputs update.
  - → WAIT.
- WAIT:
  - cs_n=1. The period counter continues.
  - When the counter reaches SAMPLE_PERIOD−1:
    - start=1 → SELECT;
    - start=0 → IDLE.
  - If the counter has already expired at LATCH exit, WAIT lasts exactly 1 cycle.
- Frame latency: CLK_DIV + 2·CLK_DIV·FRAME_BITS + 1 cycles from SELECT entry to the sample_valid pulse. This is 133 cycles at defaults.
- start deasserted during SELECT/SHIFT/LATCH: the frame completes and the outputs update, then → IDLE at period expiry.
- Outputs hold their last values in IDLE/WAIT and never glitch mid-frame.
- The period counter is wide enough for SAMPLE_PERIOD and saturates; it does not wrap.

Optional Feature:
- SENSOR_PARITY_EN defined:
  - FRAME_BITS=17; the 17th bit is even parity over the 16 data bits.
  - On mismatch, LATCH leaves temperature/water unchanged, pulses frame_err=1 and keeps sample_valid=0.
- Undefined: FRAME_BITS=16, frame_err constant 0.

Decomposition:
- Shared package `plant_pkg`:
  - state enum (IDLE/SELECT/SHIFT/LATCH/WAIT);
  - TEMP_W=3, WATER_W=4, RAW_W=8;
  - FRAME_BITS derivation.
- `fsm_plant` code widths are taken from the same constants.
- One natural sub-module, `sclk_gen`: the CLK_DIV half-period counter. It provides `sclk`, a sample strobe and a bit counter with a done flag.

Test Plan:
- Reset low with start=1 for 3 cycles, then release → cs_n=1, sclk=0, temperature=0, water=0; cs_n falls on the cycle after release.
- ADC model returns raw_t=8'hA5, raw_w=8'h3C → after 133 cycles sample_valid pulses once; temperature=3'd5, water=4'd3; exactly 16 sclk rising edges seen.
- SAMPLE_PERIOD=300, start held 1 → successive cs_n falling edges exactly 300 clk apart. With SAMPLE_PERIOD=8 → frames back-to-back with exactly 1 WAIT cycle.
- Drop start at bit 7 of a frame, ADC returns 8'hFF/8'hFF → frame completes with temperature=7, water=15, then IDLE with cs_n=1 and no further frames.
- Assert reset at bit 10 → cs_n=1 and outputs 0 immediately (asynchronous); after release with start=1 a fresh full 16-bit frame runs.
- SENSOR_PARITY_EN: send 8'h12/8'h34 with a wrong parity bit → frame_err pulse, no sample_valid, outputs keep their prior values. With correct parity → temperature=0, water=3.
